// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs every four good bytes into a little-endian 32-bit word.
// Partial words are dropped on a framing error or after an inter-byte idle timeout.
module uart_word_rx #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned TMO   = TIMEOUT_BITS * DIV;
    localparam int unsigned TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rxs;
    logic               rxs_d;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [1:0]         idx;
    logic [23:0]        shadow;
    logic [TMO_W-1:0]   tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            rxs_d       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            idx         <= '0;
            shadow      <= '0;
            tmo_cnt     <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rxs         <= rx_meta;
            rxs_d       <= rxs;
            byte_valid  <= 1'b0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end

                // Mid-start-bit check filters short low glitches.
                START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        if (rxs) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            byte_data  <= shreg;
                            byte_valid <= 1'b1;
                            case (idx)
                                2'd0:    shadow[7:0]   <= shreg;
                                2'd1:    shadow[15:8]  <= shreg;
                                2'd2:    shadow[23:16] <= shreg;
                                default: begin
                                    word_data  <= {shreg, shadow};
                                    word_valid <= 1'b1;
                                end
                            endcase
                            idx <= (idx == 2'd3) ? 2'd0 : idx + 2'd1;
                        end else begin
                            frame_error <= 1'b1;
                            idx         <= '0;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Break or stuck-low line: wait for idle before re-arming.
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Inter-byte timeout drops a stale partial word.
            if (state == IDLE && idx != 2'd0) begin
                if (tmo_cnt == TMO_W'(TMO)) begin
                    idx     <= '0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: byte/word scoreboard model plus literal word checks.
module tb_uart_word_rx;

    localparam int DIV = 10;

    logic        clk;
    logic        reset;
    logic        rx;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [31:0] word_data;
    logic        word_valid;
    logic        frame_error;
    logic        busy;

    uart_word_rx #(
        .CLK_FREQ     (1_000_000),
        .BAUD         (100_000),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: byte-level view of what the receiver must report.
    logic [7:0]  m_lane [4];
    int          m_idx = 0;
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_words [$];
    int          exp_ferr = 0;
    logic [31:0] exp_shown = 32'h0;
    int          n_words_seen = 0;
    int          n_ferr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] d, input logic stop_bit);
        if (!stop_bit) begin
            exp_ferr++;
            m_idx = 0;
        end else begin
            exp_bytes.push_back(d);
            m_lane[m_idx] = d;
            if (m_idx == 3) begin
                exp_words.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int idle_bits);
        model_frame(d, stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (idle_bits * DIV) @(negedge clk);
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            exp_shown = 32'h0;
        end else begin
            if (byte_valid) begin
                if (exp_bytes.size() == 0) chk("unexpected_byte", {24'h0, byte_data}, 32'hxxxxxxxx);
                else chk("byte_data", {24'h0, byte_data}, {24'h0, exp_bytes.pop_front()});
            end
            if (word_valid) begin
                n_words_seen++;
                if (exp_words.size() == 0) chk("unexpected_word", word_data, 32'hxxxxxxxx);
                else begin
                    exp_shown = exp_words.pop_front();
                    chk("word_data", word_data, exp_shown);
                end
            end else begin
                chk("word_hold", word_data, exp_shown);
            end
            if (frame_error) begin
                n_ferr_seen++;
                if (exp_ferr == 0) chk("unexpected_frame_error", 32'd1, 32'd0);
                else exp_ferr--;
            end
        end
    end

    int w0;
    int f0;
    int bcnt;

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_byte_data", {24'h0, byte_data}, 32'h0);
        chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        chk("rst_word_data", word_data, 32'h0);
        chk("rst_word_valid", {31'h0, word_valid}, 32'h0);
        chk("rst_frame_error", {31'h0, frame_error}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Basic word
        w0 = n_words_seen; f0 = n_ferr_seen;
        send_frame(8'h13, 1'b1, 1);
        send_frame(8'h05, 1'b1, 1);
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'h00, 1'b1, 1);
        repeat (20) @(negedge clk);
        chk("basic_word_lit", word_data, 32'h00000513);
        chk("basic_word_count", 32'(n_words_seen - w0), 32'd1);
        chk("basic_busy_idle", {31'h0, busy}, 32'h0);

        // Glitch rejection
        f0 = n_ferr_seen; bcnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        n_vec++;
        if (bcnt == 0 || bcnt >= 10) begin
            n_err++;
            $display("FAIL glitch_busy_cycles: got %0d expected 1..9", bcnt);
        end
        chk("glitch_ferr_count", 32'(n_ferr_seen - f0), 32'd0);

        // Framing error
        w0 = n_words_seen; f0 = n_ferr_seen;
        send_frame(8'hAA, 1'b1, 1);
        send_frame(8'h55, 1'b0, 1);
        send_frame(8'h78, 1'b1, 1);
        send_frame(8'h56, 1'b1, 1);
        send_frame(8'h34, 1'b1, 1);
        send_frame(8'h12, 1'b1, 1);
        repeat (20) @(negedge clk);
        chk("ferr_word_lit", word_data, 32'h12345678);
        chk("ferr_word_count", 32'(n_words_seen - w0), 32'd1);
        chk("ferr_count", 32'(n_ferr_seen - f0), 32'd1);

        // Timeout
        w0 = n_words_seen;
        send_frame(8'h01, 1'b1, 1);
        send_frame(8'h02, 1'b1, 1);
        repeat (60) @(negedge clk);
        m_idx = 0;
        send_frame(8'hEF, 1'b1, 1);
        send_frame(8'hBE, 1'b1, 1);
        send_frame(8'hAD, 1'b1, 1);
        send_frame(8'hDE, 1'b1, 1);
        repeat (20) @(negedge clk);
        chk("tmo_word_lit", word_data, 32'hDEADBEEF);
        chk("tmo_word_count", 32'(n_words_seen - w0), 32'd1);

        // Back-to-back then break
        w0 = n_words_seen; f0 = n_ferr_seen;
        for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 0);
        exp_ferr++;
        m_idx = 0;
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("b2b_word_lit", word_data, 32'h07060504);
        chk("b2b_word_count", 32'(n_words_seen - w0), 32'd2);
        chk("break_ferr_count", 32'(n_ferr_seen - f0), 32'd1);
        chk("break_busy_idle", {31'h0, busy}, 32'h0);

        // Reset during data bit 4
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        chk("pre_reset_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_word_data", word_data, 32'h0);
        chk("mid_rst_byte_data", {24'h0, byte_data}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_strobes", {29'h0, byte_valid, word_valid, frame_error}, 32'h0);
        m_idx = 0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        w0 = n_words_seen;
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        send_frame(8'h33, 1'b1, 1);
        send_frame(8'h44, 1'b1, 1);
        repeat (20) @(negedge clk);
        chk("rst_word_lit", word_data, 32'h44332211);
        chk("rst_word_count", 32'(n_words_seen - w0), 32'd1);

        chk("bytes_outstanding", 32'(exp_bytes.size()), 32'd0);
        chk("words_outstanding", 32'(exp_words.size()), 32'd0);
        chk("ferr_outstanding", 32'(exp_ferr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
